// File: rtl/phase_sequencer.sv
// Master phase sequencer: 16-state Johnson phase bus, derived CPU/CRTC clocks,
// and an HSYNC-retimed screen mode with a delayed MODE_SYNC strobe.
module phase_sequencer #(
  parameter int unsigned READY_FIRST = 12,
  parameter int unsigned READY_LAST  = 15
) (
  input  logic       CLK_n,
  input  logic       RESET,
  input  logic       MODE_WR,
  input  logic [1:0] MODE_IN,
  input  logic       HSYNC,
  output logic [7:0] S,
  output logic [3:0] PHASE,
  output logic       PHI_n,
  output logic       READY,
  output logic       CCLK,
  output logic [1:0] MODE,
  output logic       MODE_SYNC
);

  logic [7:0] s_q, s_d;
  logic       phi_n_q, phi_n_d;
  logic       ready_q, ready_d;
  logic       cclk_q, cclk_d;
  logic [1:0] pending_q, pending_d;
  logic [1:0] mode_q, mode_d;
  logic       hsync_q, hsync_d;
  logic       edge_seen_q, edge_seen_d;
  logic       mode_sync_q, mode_sync_d;

  logic [3:0] phase_cur;
  logic [3:0] phase_nxt;
  logic       legal;
  logic       hsync_rise;

  function automatic logic [3:0] phase_of(input logic [7:0] code);
    logic [3:0] ones;
    ones = '0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'b000, code[i]};
    end
    if (code[7]) phase_of = 4'd8 + (4'd8 - ones);
    else         phase_of = ones;
  endfunction

  // Canonical Johnson code for a phase index; any other S value is illegal.
  function automatic logic [7:0] code_of(input logic [3:0] k);
    if (k[3]) code_of = 8'hFF << k[2:0];
    else      code_of = 8'hFF >> (4'd8 - k);
  endfunction

  always_comb begin
    phase_cur = phase_of(s_q);
    legal     = (s_q == code_of(phase_cur));
    s_d       = 8'h00;
    phase_nxt = 4'd0;
    if (legal) begin
      s_d       = {s_q[6:0], ~s_q[7]};
      phase_nxt = phase_cur + 4'd1;
    end
    phi_n_d = ~phase_nxt[1];
    ready_d = ({28'd0, phase_nxt} >= READY_FIRST) && ({28'd0, phase_nxt} <= READY_LAST);
    cclk_d  = s_d[7];
  end

  // Mode uses the pending value from before any write in the same cycle.
  always_comb begin
    hsync_rise  = HSYNC & ~hsync_q;
    hsync_d     = HSYNC;
    pending_d   = MODE_WR ? MODE_IN : pending_q;
    mode_d      = hsync_rise ? pending_q : mode_q;
    edge_seen_d = hsync_rise;
    mode_sync_d = edge_seen_q;
  end

  always_ff @(posedge CLK_n) begin
    if (RESET) begin
      s_q         <= 8'h00;
      phi_n_q     <= 1'b1;
      ready_q     <= 1'b0;
      cclk_q      <= 1'b0;
      pending_q   <= 2'b00;
      mode_q      <= 2'b00;
      hsync_q     <= 1'b0;
      edge_seen_q <= 1'b0;
      mode_sync_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      phi_n_q     <= phi_n_d;
      ready_q     <= ready_d;
      cclk_q      <= cclk_d;
      pending_q   <= pending_d;
      mode_q      <= mode_d;
      hsync_q     <= hsync_d;
      edge_seen_q <= edge_seen_d;
      mode_sync_q <= mode_sync_d;
    end
  end

  assign S         = s_q;
  assign PHASE     = phase_cur;
  assign PHI_n     = phi_n_q;
  assign READY     = ready_q;
  assign CCLK      = cclk_q;
  assign MODE      = mode_q;
  assign MODE_SYNC = mode_sync_q;

endmodule
